// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer shared types and defaults.
// State encodings are fixed: debug tools decode state_out directly.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    FSEQ_RUN      = 2'd0,
    FSEQ_SWAP1    = 2'd1,
    FSEQ_SWAP2    = 2'd2,
    FSEQ_MEM_WAIT = 2'd3
  } fseq_state_t;

  localparam int FSEQ_DEF_STALL_CNT_W = 16;
  localparam int FSEQ_DEF_MEM_TIMEOUT = 255;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Status inputs and IF-stage control outputs of fetch_sequencer.
// master = status source / IF side, slave = the sequencer.
interface fetch_sequencer_if #(
  parameter int STALL_CNT_W = 16
);

  logic                   hazard_in;
  logic                   branch_taken_in;
  logic                   swap_detect_in;
  logic                   mem_req_in;
  logic                   mem_ready_in;
  logic                   freeze_out;
  logic                   flush_out;
  logic                   stop_if_out;
  logic                   swap_2_out;
  logic [1:0]             state_out;
  logic [STALL_CNT_W-1:0] stall_cycles_out;
  logic                   err_out;

  modport master (
    output hazard_in,
    output branch_taken_in,
    output swap_detect_in,
    output mem_req_in,
    output mem_ready_in,
    input  freeze_out,
    input  flush_out,
    input  stop_if_out,
    input  swap_2_out,
    input  state_out,
    input  stall_cycles_out,
    input  err_out
  );

  modport slave (
    input  hazard_in,
    input  branch_taken_in,
    input  swap_detect_in,
    input  mem_req_in,
    input  mem_ready_in,
    output freeze_out,
    output flush_out,
    output stop_if_out,
    output swap_2_out,
    output state_out,
    output stall_cycles_out,
    output err_out
  );

endinterface

// File: rtl/fetch_sequencer_mem_wait_watchdog.sv
// mem_wait_watchdog: counts consecutive MEM_WAIT cycles,
// pulses o_timeout on the MEM_TIMEOUT-th one, sticky o_err.
module mem_wait_watchdog #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_in_wait,
  output logic o_timeout,
  output logic o_err
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic          w_hit;

  assign w_hit = i_in_wait &&
                 (r_cnt == CW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      // cleared outside MEM_WAIT so each entry starts at 0
      if (!i_in_wait || w_hit)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
      if (w_hit)
        r_err <= 1'b1;
    end
  end

  assign o_timeout = w_hit;
  assign o_err     = r_err;

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage pipeline control: SWP sequencing and data-memory stalls.
// Define FETCH_SEQ_TIMEOUT_EN to enable the MEM_WAIT watchdog.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int STALL_CNT_W = FSEQ_DEF_STALL_CNT_W
`ifdef FETCH_SEQ_TIMEOUT_EN
  ,
  parameter int MEM_TIMEOUT = FSEQ_DEF_MEM_TIMEOUT
`endif
) (
  input  logic              clk,
  input  logic              rst,
  fetch_sequencer_if.slave  bus
);

  fseq_state_t            r_state;
  fseq_state_t            r_ret;
  fseq_state_t            w_state_nxt;
  fseq_state_t            w_ret_nxt;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic w_mem_stall;
  logic w_timeout;
  logic w_err;
  logic w_freeze;
  logic w_flush;
  logic w_stop_if;
  logic w_swap_2;
  logic w_in_wait;

  assign w_mem_stall = bus.mem_req_in & ~bus.mem_ready_in;
  assign w_in_wait   = (r_state == FSEQ_MEM_WAIT);

`ifdef FETCH_SEQ_TIMEOUT_EN
  mem_wait_watchdog #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .i_in_wait (w_in_wait),
    .o_timeout (w_timeout),
    .o_err     (w_err)
  );
`else
  assign w_timeout = 1'b0;
  assign w_err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= FSEQ_RUN;
      r_ret   <= FSEQ_RUN;
    end else begin
      r_state <= w_state_nxt;
      r_ret   <= w_ret_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ret_nxt   = r_ret;
    w_flush     = 1'b0;
    w_stop_if   = 1'b0;
    w_swap_2    = 1'b0;
    w_freeze    = w_in_wait | w_mem_stall |
                  bus.hazard_in;
    unique case (r_state)
      FSEQ_MEM_WAIT: begin
        // EXE is frozen, so a branch here is stale
        if (bus.mem_ready_in || w_timeout)
          w_state_nxt = r_ret;
      end
      FSEQ_RUN: begin
        if (w_mem_stall) begin
          w_state_nxt = FSEQ_MEM_WAIT;
          w_ret_nxt   = FSEQ_RUN;
        end else if (bus.branch_taken_in) begin
          w_flush = 1'b1;
        end else if (!bus.hazard_in &&
                     bus.swap_detect_in) begin
          w_state_nxt = FSEQ_SWAP1;
        end
      end
      FSEQ_SWAP1, FSEQ_SWAP2: begin
        w_stop_if = 1'b1;
        w_swap_2  = (r_state == FSEQ_SWAP2);
        if (w_mem_stall) begin
          w_state_nxt = FSEQ_MEM_WAIT;
          w_ret_nxt   = r_state;
        end else if (bus.branch_taken_in) begin
          w_flush     = 1'b1;
          w_state_nxt = FSEQ_RUN;
        end else if (!bus.hazard_in) begin
          w_state_nxt = (r_state == FSEQ_SWAP1) ?
                        FSEQ_SWAP2 : FSEQ_RUN;
        end
      end
      default: w_state_nxt = FSEQ_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_stall_cnt <= '0;
    else if (w_freeze && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  // combinational controls read 0 while reset is held
  assign bus.freeze_out       = rst & w_freeze;
  assign bus.flush_out        = rst & w_flush;
  assign bus.stop_if_out      = rst & w_stop_if;
  assign bus.swap_2_out       = rst & w_swap_2;
  assign bus.state_out        = r_state;
  assign bus.stall_cycles_out = r_stall_cnt;
  assign bus.err_out          = w_err;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vectors, per-cycle model compare.
// Two instances share inputs: wide and 2-bit saturating stall counter.
module tb_fetch_sequencer;

  localparam int W_BIG = 16;
  localparam int W_SAT = 2;
  localparam int TB_TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic haz = 1'b0;
  logic br  = 1'b0;
  logic swp = 1'b0;
  logic req = 1'b0;
  logic rdy = 1'b0;

  always #5 clk = ~clk;

  fetch_sequencer_if #(.STALL_CNT_W(W_BIG)) bus_a ();
  fetch_sequencer_if #(.STALL_CNT_W(W_SAT)) bus_b ();

  assign bus_a.hazard_in       = haz;
  assign bus_a.branch_taken_in = br;
  assign bus_a.swap_detect_in  = swp;
  assign bus_a.mem_req_in      = req;
  assign bus_a.mem_ready_in    = rdy;
  assign bus_b.hazard_in       = haz;
  assign bus_b.branch_taken_in = br;
  assign bus_b.swap_detect_in  = swp;
  assign bus_b.mem_req_in      = req;
  assign bus_b.mem_ready_in    = rdy;

  fetch_sequencer #(
    .STALL_CNT_W (W_BIG)
`ifdef FETCH_SEQ_TIMEOUT_EN
    , .MEM_TIMEOUT (TB_TO)
`endif
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  fetch_sequencer #(
    .STALL_CNT_W (W_SAT)
`ifdef FETCH_SEQ_TIMEOUT_EN
    , .MEM_TIMEOUT (TB_TO)
`endif
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int n_vec = 0;
  int n_bad = 0;

  // model: state number, return state, freeze tally
  int m_st   = 0;
  int m_ret  = 0;
  int m_cnt  = 0;
  int m_wait = 0;
  bit m_err  = 1'b0;
  int x_st   = 0;
  int x_ret  = 0;
  int x_cnt  = 0;
  int x_wait = 0;
  bit x_err  = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d @%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  always @(negedge rst) begin
    m_st = 0; m_ret = 0; m_cnt = 0;
    m_wait = 0; m_err = 1'b0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_st = x_st; m_ret = x_ret; m_cnt = x_cnt;
      m_wait = x_wait; m_err = x_err;
    end
  end

  always @(negedge clk) begin
    bit ms, e_fr, e_fl, e_st, e_sw;
    ms = req && !rdy;
    e_fr = 1'b0; e_fl = 1'b0;
    e_st = 1'b0; e_sw = 1'b0;
    if (rst) begin
      e_fr = (m_st == 3) || ms || haz;
      e_fl = (m_st != 3) && !ms && br;
      e_st = (m_st == 1) || (m_st == 2);
      e_sw = (m_st == 2);
    end
    chk("freeze_a", bus_a.freeze_out, e_fr);
    chk("freeze_b", bus_b.freeze_out, e_fr);
    chk("flush", bus_a.flush_out, e_fl);
    chk("stop_if", bus_a.stop_if_out, e_st);
    chk("swap_2", bus_a.swap_2_out, e_sw);
    chk("state_a", bus_a.state_out, m_st);
    chk("state_b", bus_b.state_out, m_st);
    chk("stall_a", bus_a.stall_cycles_out,
        sat(m_cnt, W_BIG));
    chk("stall_b", bus_b.stall_cycles_out,
        sat(m_cnt, W_SAT));
    chk("err_a", bus_a.err_out, m_err);
    chk("err_b", bus_b.err_out, m_err);
    x_st = m_st; x_ret = m_ret; x_wait = m_wait;
    x_err = m_err; x_cnt = m_cnt + (e_fr ? 1 : 0);
    if (!rst) begin
      x_st = 0; x_ret = 0; x_wait = 0;
      x_err = 1'b0; x_cnt = 0;
    end else if (m_st == 3) begin
      x_wait = m_wait + 1;
`ifdef FETCH_SEQ_TIMEOUT_EN
      if (x_wait == TB_TO) begin
        x_err = 1'b1;
        x_st  = m_ret;
      end
`endif
      if (rdy) x_st = m_ret;
    end else if (ms) begin
      x_ret = m_st;
      x_st  = 3;
    end else if (br) begin
      x_st = 0;
    end else if (!haz) begin
      if (m_st == 0) x_st = swp ? 1 : 0;
      else           x_st = (m_st + 1) % 3;
    end
    if (x_st != 3) x_wait = 0;
  end

  task automatic drv(input bit h, input bit b,
                     input bit s, input bit q,
                     input bit y);
    @(posedge clk);
    #1;
    haz = h; br = b; swp = s; req = q; rdy = y;
    #1;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // single-cycle SWP, no stalls
    drv(0, 0, 1, 0, 0);
    chk("a_run_stop", bus_a.stop_if_out, 0);
    idle();
    chk("a_s1_stop", bus_a.stop_if_out, 1);
    chk("a_s1_sw2", bus_a.swap_2_out, 0);
    idle();
    chk("a_s2_stop", bus_a.stop_if_out, 1);
    chk("a_s2_sw2", bus_a.swap_2_out, 1);
    idle();
    chk("a_back_run", bus_a.state_out, 0);
    chk("a_back_stop", bus_a.stop_if_out, 0);

    // memory stall during SWAP1
    drv(0, 0, 1, 0, 0);
    drv(0, 0, 0, 1, 0);
    chk("b_entry_frz", bus_a.freeze_out, 1);
    chk("b_entry_st", bus_a.state_out, 1);
    drv(0, 0, 0, 1, 0);
    chk("b_wait_st", bus_a.state_out, 3);
    drv(0, 0, 0, 1, 0);
    drv(0, 0, 0, 0, 1);
    chk("b_exit_frz", bus_a.freeze_out, 1);
    idle();
    chk("b_resume_st", bus_a.state_out, 1);
    chk("b_resume_frz", bus_a.freeze_out, 0);
    chk("b_cnt_a", bus_a.stall_cycles_out, 4);
    chk("b_cnt_b", bus_b.stall_cycles_out, 3);
    idle();
    chk("b_s2_st", bus_a.state_out, 2);
    idle();

    // branch aborts SWAP2
    drv(0, 0, 1, 0, 0);
    idle();
    drv(0, 1, 0, 0, 0);
    chk("c_flush", bus_a.flush_out, 1);
    idle();
    chk("c_st", bus_a.state_out, 0);
    chk("c_sw2", bus_a.swap_2_out, 0);
    chk("c_flush_off", bus_a.flush_out, 0);

    // hazard holds SWAP1, and blocks SWP entry
    drv(0, 0, 1, 0, 0);
    drv(1, 0, 0, 0, 0);
    chk("d_haz_frz", bus_a.freeze_out, 1);
    drv(1, 0, 0, 0, 0);
    idle();
    chk("d_held_st", bus_a.state_out, 1);
    idle();
    idle();
    drv(1, 0, 1, 0, 0);
    idle();
    chk("d_run_st", bus_a.state_out, 0);

    // branch in RUN, branch ignored in MEM_WAIT
    drv(0, 1, 0, 0, 0);
    chk("e_run_flush", bus_a.flush_out, 1);
    drv(0, 0, 0, 1, 0);
    drv(0, 1, 0, 0, 0);
    chk("e_mw_flush", bus_a.flush_out, 0);
    chk("e_mw_frz", bus_a.freeze_out, 1);
    drv(0, 0, 0, 0, 1);
    idle();
    chk("e_run_st", bus_a.state_out, 0);
    drv(0, 1, 0, 1, 0);
    chk("e_pri_flush", bus_a.flush_out, 0);
    drv(0, 0, 0, 0, 1);
    idle();

    // stall counter saturation
    repeat (6) drv(1, 0, 0, 0, 0);
    idle();
    chk("f_cnt_a", bus_a.stall_cycles_out, 18);
    chk("f_cnt_b", bus_b.stall_cycles_out, 3);

    // asynchronous reset mid-SWAP2
    drv(0, 0, 1, 0, 0);
    idle();
    idle();
    chk("g_pre_st", bus_a.state_out, 2);
    #1 rst = 1'b0;
    #1;
    chk("g_rst_st", bus_a.state_out, 0);
    chk("g_rst_stop", bus_a.stop_if_out, 0);
    chk("g_rst_cnt", bus_a.stall_cycles_out, 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // MEM_WAIT with ready held low
    drv(0, 0, 1, 0, 0);
    drv(0, 0, 0, 1, 0);
    repeat (4) idle();
`ifdef FETCH_SEQ_TIMEOUT_EN
    chk("h_err_pre", bus_a.err_out, 0);
    idle();
    chk("h_err", bus_a.err_out, 1);
    chk("h_ret_st", bus_a.state_out, 1);
    idle();
    chk("h_err_hold", bus_a.err_out, 1);
`else
    chk("h_still_wait", bus_a.state_out, 3);
    drv(0, 0, 0, 0, 1);
    idle();
    chk("h_ret_st", bus_a.state_out, 1);
    chk("h_no_err", bus_a.err_out, 0);
`endif
    repeat (4) idle();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
